// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one single-port SDRAM controller between the core's
// instruction-fetch port (I) and load/store port (D).
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   i_req/i_addr/i_width        I request (read only), held until i_ack
//   i_rdata/i_ack               I read data and one-cycle completion pulse
//   d_req/d_write/d_addr/
//   d_wdata/d_width             D request, held until d_ack
//   d_rdata/d_ack               D read data and one-cycle completion pulse
//   m_enable/m_addr/m_write/
//   m_wdata/m_width             request toward the controller
//   m_rdata/m_ready             controller read data and ready
//   owner                       port of the current or last grant (1 = D)
//   err                         sticky controller-stall flag
//
// D wins contention until it has taken FAIR_LIMIT grants in a row while I
// waited; a transaction stuck in WAIT_LO/WAIT_HI for TIMEOUT cycles parks the
// arbiter in ERROR until reset. Every output is registered.

package sdram_arbiter_pkg;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  // Request fields latched at grant and held toward the controller
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] width;
  } mreq_t;
endpackage

module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [SIZE_W-1:0] i_width,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  // load/store port
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [SIZE_W-1:0] d_width,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // controller side
  output logic              m_enable,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  output logic [SIZE_W-1:0] m_width,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  // status
  output logic              owner,
  output logic              err
);

  localparam int unsigned FAIR_LOG = $clog2(FAIR_LIMIT + 1);
  localparam int unsigned FAIR_W   = (FAIR_LOG > 3) ? FAIR_LOG : 3;
  localparam int unsigned TMO_W    = 10;

  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESP    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  mreq_t               mreq_q, mreq_d;
  logic [FAIR_W-1:0]   fair_q, fair_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                m_enable_d;
  logic                owner_d;
  logic                err_d;
  logic                i_ack_d, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_d, d_rdata_d;
  logic                pick_d;
  logic                tmo_hit;

  // D wins unless I is also waiting and D has used up its streak
  assign pick_d  = d_req && !(i_req && (fair_q == FAIR_MAX));
  assign tmo_hit = (tmo_q == TMO_MAX);

  assign m_addr  = mreq_q.addr;
  assign m_write = mreq_q.write;
  assign m_wdata = mreq_q.wdata;
  assign m_width = mreq_q.width;

  // Next-state and registered-output values
  always_comb begin
    state_d    = state_q;
    mreq_d     = mreq_q;
    fair_d     = fair_q;
    tmo_d      = tmo_q;
    m_enable_d = 1'b0;
    owner_d    = owner;
    err_d      = err;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    i_rdata_d  = i_rdata;
    d_rdata_d  = d_rdata;

    case (state_q)
      IDLE: begin
        if (!i_req) begin
          fair_d = '0;
        end
        // ready low (controller still initialising) blocks every grant
        if (m_ready && (i_req || d_req)) begin
          state_d    = ISSUE;
          m_enable_d = 1'b1;
          tmo_d      = '0;
          if (pick_d) begin
            owner_d = 1'b1;
            mreq_d  = '{write: d_write, addr: d_addr, wdata: d_wdata, width: d_width};
            if (i_req && (fair_q != FAIR_MAX)) begin
              fair_d = fair_q + FAIR_W'(1);
            end
          end else begin
            owner_d = 1'b0;
            mreq_d  = '{write: 1'b0, addr: i_addr, wdata: '0, width: i_width};
            fair_d  = '0;
          end
        end
      end

      // ready may be a stale 1 during refresh: hold enable until it drops
      ISSUE: begin
        if (m_ready) begin
          m_enable_d = 1'b1;
        end else begin
          state_d = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (tmo_hit) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (m_ready) begin
            state_d = WAIT_HI;
          end
        end
      end

      // controller data is valid here; route it to the owner with its ack
      WAIT_HI: begin
        if (tmo_hit) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
          state_d = RESP;
          if (owner) begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      ERROR: begin
        err_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mreq_q   <= '0;
      fair_q   <= '0;
      tmo_q    <= '0;
      m_enable <= 1'b0;
      owner    <= 1'b0;
      err      <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      fair_q   <= fair_d;
      tmo_q    <= tmo_d;
      m_enable <= m_enable_d;
      owner    <= owner_d;
      err      <= err_d;
      i_ack    <= i_ack_d;
      d_ack    <= d_ack_d;
      i_rdata  <= i_rdata_d;
      d_rdata  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a behavioural
// controller model and an ack-ordered scoreboard of expected completions.
`timescale 1ns/1ps

module tb_sdram_arbiter;

  localparam int unsigned FAIR_LIMIT = 4;
  localparam int unsigned TIMEOUT    = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write;
  logic [23:0] i_addr, d_addr;
  logic [1:0]  i_width, d_width;
  logic [31:0] d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic        m_enable, m_write, m_ready;
  logic [23:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [1:0]  m_width;
  logic        owner, err;

  always #5 clk = ~clk;

  sdram_arbiter #(.FAIR_LIMIT(FAIR_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_width(i_width), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_enable(m_enable), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata),
    .m_width(m_width), .m_rdata(m_rdata), .m_ready(m_ready),
    .owner(owner), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Controller data pattern; one address carries the classic read value
  function automatic logic [31:0] rd_fn(input logic [23:0] a);
    if (a == 24'h000102) return 32'hDEADBEEF;
    return {a[7:0], a} ^ 32'hA5A5_0000;
  endfunction

  // ---------------- controller model ----------------
  typedef enum logic [1:0] {M_IDLE, M_REF, M_BUSY} mst_t;
  mst_t        mst;
  int          ref_left, busy_left;
  int          captures = 0;
  logic [23:0] cap_addr;
  logic        cap_write;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_width;
  int          refresh_cfg = 0;
  int          busy_cfg    = 3;
  bit          hang        = 1'b0;
  bit          mdl_hold    = 1'b1;
  bit          mdl_abort   = 1'b0;

  always @(posedge clk) begin
    if (mdl_hold || mdl_abort) begin
      m_ready <= 1'b0;
      mst     <= M_IDLE;
    end else begin
      case (mst)
        M_IDLE: begin
          m_ready <= 1'b1;
          if (m_enable) begin
            if (refresh_cfg > 1) begin
              mst      <= M_REF;
              ref_left <= refresh_cfg - 1;
            end else begin
              captures  <= captures + 1;
              cap_addr  <= m_addr;
              cap_write <= m_write;
              cap_wdata <= m_wdata;
              cap_width <= m_width;
              m_ready   <= 1'b0;
              busy_left <= busy_cfg;
              mst       <= M_BUSY;
            end
          end
        end
        M_REF: begin
          if (ref_left <= 1) begin
            captures  <= captures + 1;
            cap_addr  <= m_addr;
            cap_write <= m_write;
            cap_wdata <= m_wdata;
            cap_width <= m_width;
            m_ready   <= 1'b0;
            busy_left <= busy_cfg;
            mst       <= M_BUSY;
          end else begin
            ref_left <= ref_left - 1;
          end
        end
        M_BUSY: begin
          if (!hang) begin
            if (busy_left <= 1) begin
              m_ready <= 1'b1;
              m_rdata <= rd_fn(cap_addr);
              mst     <= M_IDLE;
            end else begin
              busy_left <= busy_left - 1;
            end
          end
        end
        default: mst <= M_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    bit          port;    // 1 = D
    logic [31:0] rdata;
    bit          chk_rd;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   ack_total  = 0;
  int   en_cycles  = 0;
  logic prev_ack   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    en_cycles <= en_cycles + (m_enable ? 1 : 0);
    if (rst !== 1'b1) begin
      prev_ack = 1'b0;
    end else begin
      if (i_ack || d_ack) begin
        ack_total++;
        chk("ack_one_hot", 32'(i_ack & d_ack), 32'd0);
        chk("ack_pulse_width", 32'(prev_ack), 32'd0);
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_port"}, 32'(d_ack), 32'(e.port));
          if (e.chk_rd) chk({e.tag, "_rdata"}, e.port ? d_rdata : i_rdata, e.rdata);
        end
      end
      prev_ack = i_ack | d_ack;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_acks(input int n, input int budget, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) got++;
    end
    chk({tag, "_ack_count"}, 32'(got), 32'(n));
  endtask

  task automatic d_txn(input bit wr, input logic [23:0] a, input logic [31:0] wd,
                       input logic [1:0] w, input string tag);
    exp_t e;
    e.port = 1'b1; e.rdata = rd_fn(a); e.chk_rd = !wr; e.tag = tag;
    sb.push_back(e);
    d_write = wr; d_addr = a; d_wdata = wd; d_width = w; d_req = 1'b1;
    wait_acks(1, 200, tag);
    d_req = 1'b0;
  endtask

  task automatic i_txn(input logic [23:0] a, input logic [1:0] w, input string tag);
    exp_t e;
    e.port = 1'b0; e.rdata = rd_fn(a); e.chk_rd = 1'b1; e.tag = tag;
    sb.push_back(e);
    i_addr = a; i_width = w; i_req = 1'b1;
    wait_acks(1, 200, tag);
    i_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    exp_t e;
    int   e0, c0, a0, cyc, bad;
    bit   seen, got;

    rst = 1'b0;
    i_req = 1'b0; i_addr = '0; i_width = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_width = '0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_m_enable", 32'(m_enable), 32'd0);
    chk("rst_m_fields", 32'({m_write, m_width} | 3'(m_addr != 0) | 3'(m_wdata != 0)), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_owner_err", 32'({owner, err}), 32'd0);
    rst = 1'b1;

    // init hold: controller not ready blocks the grant
    e.port = 1'b1; e.rdata = 32'hDEADBEEF; e.chk_rd = 1'b1; e.tag = "d_read";
    sb.push_back(e);
    d_addr = 24'h000102; d_width = 2'd2; d_write = 1'b0; d_wdata = 32'h0BAD_F00D; d_req = 1'b1;
    e0 = en_cycles;
    repeat (100) @(negedge clk);
    chk("init_hold_enable_cycles", 32'(en_cycles - e0), 32'd0);
    mdl_hold = 1'b0;
    @(negedge clk);
    chk("init_enable_first_cycle", 32'(m_enable), 32'd0);
    @(negedge clk);
    chk("init_enable_second_cycle", 32'(m_enable), 32'd1);
    chk("d_grant_owner", 32'(owner), 32'd1);
    wait_acks(1, 200, "d_read");
    chk("d_read_no_iack", 32'(i_ack), 32'd0);
    d_req = 1'b0;
    chk("d_read_capture_addr", 32'(cap_addr), 32'h000102);

    // I read; D fields left wiggling must not leak into the request
    d_write = 1'b1; d_wdata = 32'hFFFF_0000;
    i_txn(24'h0000AA, 2'd1, "i_read");
    chk("i_read_m_write", 32'(m_write), 32'd0);
    chk("i_read_m_wdata", m_wdata, 32'd0);
    chk("i_read_owner", 32'(owner), 32'd0);
    chk("i_read_cap_width", 32'(cap_width), 32'd1);
    repeat (3) @(negedge clk);
    chk("i_rdata_hold", i_rdata, rd_fn(24'h0000AA));

    // refresh stall: stale ready keeps enable up, single capture
    refresh_cfg = 6;
    c0 = captures; e0 = en_cycles;
    d_txn(1'b0, 24'h000200, 32'h0, 2'd2, "refresh_read");
    refresh_cfg = 0;
    chk("refresh_captures", 32'(captures - c0), 32'd1);
    chk("refresh_enable_cycles", 32'(en_cycles - e0), 32'd7);

    // write passthrough, fields stable from grant to ack
    e.port = 1'b1; e.rdata = 32'h0; e.chk_rd = 1'b0; e.tag = "d_write";
    sb.push_back(e);
    d_write = 1'b1; d_addr = 24'h000345; d_wdata = 32'h12345678; d_width = 2'd1; d_req = 1'b1;
    seen = 1'b0; got = 1'b0; cyc = 0; bad = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_enable) seen = 1'b1;
      if (seen && (m_write !== 1'b1 || m_wdata !== 32'h12345678 || m_width !== 2'd1 ||
                   m_addr !== 24'h000345)) bad++;
      if (d_ack) got = 1'b1;
    end
    d_req = 1'b0;
    chk("wr_ack_seen", 32'(got), 32'd1);
    chk("wr_fields_stable", 32'(bad), 32'd0);
    chk("wr_cap_write", 32'(cap_write), 32'd1);
    chk("wr_cap_wdata", cap_wdata, 32'h12345678);
    chk("wr_cap_width", 32'(cap_width), 32'd1);

    // fairness: both ports held high, D streak capped at FAIR_LIMIT
    busy_cfg = 2;
    d_write = 1'b0; d_addr = 24'h000300; d_width = 2'd2;
    i_addr = 24'h000400; i_width = 2'd2;
    for (int k = 0; k < 10; k++) begin
      e.port = ((k % 5) != 4); e.chk_rd = 1'b1;
      e.rdata = e.port ? rd_fn(24'h000300) : rd_fn(24'h000400);
      e.tag = $sformatf("fair_%0d", k);
      sb.push_back(e);
    end
    d_req = 1'b1; i_req = 1'b1;
    wait_acks(10, 400, "fairness");
    d_req = 1'b0; i_req = 1'b0;
    busy_cfg = 3;
    repeat (3) @(negedge clk);
    chk("fair_sb_drained", 32'(sb.size()), 32'd0);

    // timeout: controller never returns ready
    hang = 1'b1;
    a0 = ack_total;
    d_write = 1'b0; d_addr = 24'h000500; d_req = 1'b1;
    repeat (1000) @(negedge clk);
    chk("tmo_err_early", 32'(err), 32'd0);
    cyc = 0;
    while (err !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_err_set", 32'(err), 32'd1);
    repeat (10) @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    chk("tmo_enable_low", 32'(m_enable), 32'd0);
    chk("tmo_no_ack", 32'(ack_total - a0), 32'd0);

    #2 rst = 1'b0;
    #1;
    chk("tmo_rst_err", 32'(err), 32'd0);
    d_req = 1'b0; mdl_abort = 1'b1; hang = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; mdl_abort = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of WAIT_LO abandons the transaction
    busy_cfg = 30;
    d_addr = 24'h000600; d_req = 1'b1;
    seen = 1'b0; cyc = 0;
    while (cyc < 100 && !(seen && !m_enable)) begin
      @(negedge clk);
      cyc++;
      if (m_enable) seen = 1'b1;
    end
    chk("mid_wait_lo_reached", 32'(seen && !m_enable), 32'd1);
    repeat (3) @(negedge clk);
    a0 = ack_total;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    chk("mid_rst_i_rdata", i_rdata, 32'd0);
    chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
    chk("mid_rst_m_ctl", 32'({m_enable, m_write, m_width, i_ack, d_ack, err}), 32'd0);
    d_req = 1'b0; mdl_abort = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; mdl_abort = 1'b0; busy_cfg = 3;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_ack", 32'(ack_total - a0), 32'd0);
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
